// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master that moves tx_last-delimited byte frames
// between a valid/ready byte stream and an SPI slave, holding ss low for the whole frame.
module spi_frame_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    input  logic       miso,
    output logic       ss,
    output logic       sck,
    output logic       mosi
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, TRAIL, GAP} state_t;

    state_t     state, state_nx;
    logic [7:0] div_cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;
    logic [2:0] bit_cnt;
    logic       last_q;
    logic       phase_end;
    logic       byte_end;
    logic       hs;

    assign phase_end = div_cnt == 8'(CLK_DIV - 1);
    assign byte_end  = state == HIGH && phase_end && bit_cnt == 3'd0;
    // The final HIGH cycle of a non-last byte accepts the next byte so it follows with no gap.
    assign tx_ready  = reset_n && (state == IDLE || state == WAIT || (byte_end && !last_q));
    assign hs        = tx_valid && tx_ready;
    assign sck       = state == HIGH;
    assign ss        = state == IDLE || state == GAP;
    assign busy      = state != IDLE;
    assign mosi      = tx_sh[7];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hs ? LOW : IDLE;
            LOW:     state_nx = phase_end ? HIGH : LOW;
            HIGH:    state_nx = !phase_end ? HIGH : bit_cnt != 3'd0 ? LOW : last_q ? TRAIL : hs ? LOW : WAIT;
            WAIT:    state_nx = hs ? LOW : WAIT;
            TRAIL:   state_nx = phase_end ? GAP : TRAIL;
            GAP:     state_nx = phase_end ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    // The shifter is not advanced after bit 0, so mosi keeps showing it through WAIT and TRAIL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            last_q   <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else begin
            div_cnt  <= state_nx != state ? 8'd0 : div_cnt + 8'd1;
            rx_valid <= byte_end;
            if (hs) begin
                tx_sh   <= tx_data;
                last_q  <= tx_last;
                bit_cnt <= 3'd7;
            end else if (state == HIGH && phase_end && bit_cnt != 3'd0) begin
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt - 3'd1;
            end
            if (state == LOW && phase_end)
                rx_sh <= {rx_sh[6:0], miso};
            if (byte_end)
                rx_data <= rx_sh;
        end
    end
endmodule
